// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM/IO port. Round-robin shares it between
// instruction fetch and the load/store buffer, serialising requests into byte beats.
module mem_arbiter #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e      state_q, state_d;
    logic        last_lsb_q, last_lsb_d;
    logic        own_lsb_q, own_lsb_d;
    logic        io_q, io_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        gnt_if, gnt_lsb, lsb_io, abort;
    logic [2:0]  lsb_n, cnt_inc;
    logic [1:0]  cnt_m1;

    assign lsb_io  = (lsb_addr[17:16] == IO_ADDR_HI);
    assign abort   = flush && !own_lsb_q && (state_q == READ || state_q == DONE);
    assign cnt_inc = cnt_q + 3'd1;
    assign cnt_m1  = cnt_q[1:0] - 2'd1;

    always_comb begin
        case (lsb_size)
            2'd0:    lsb_n = 3'd1;
            2'd1:    lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

    // A flush blocks only the fetch side of arbitration.
    always_comb begin
        gnt_if  = 1'b0;
        gnt_lsb = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && !flush && lsb_req) begin
                gnt_if  = last_lsb_q;
                gnt_lsb = !last_lsb_q;
            end else if (if_req && !flush) begin
                gnt_if = 1'b1;
            end else if (lsb_req) begin
                gnt_lsb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_lsb_q  <= 1'b1;
            own_lsb_q   <= 1'b0;
            io_q        <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsb_q  <= last_lsb_d;
            own_lsb_q   <= own_lsb_d;
            io_q        <= io_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (gnt_if)       state_d = READ;
                    else if (gnt_lsb) state_d = lsb_we ? WRITE : READ;
                end
                READ: begin
                    if (abort)              state_d = IDLE;
                    else if (cnt_q == n_q)  state_d = DONE;
                end
                WRITE: if (cnt_q == n_q) state_d = DONE;
                DONE:  state_d = IDLE;
            endcase
        end
    end

    // Read beats run one cycle ahead of capture: cnt_q counts beats already presented.
    always_comb begin
        last_lsb_d  = last_lsb_q;
        own_lsb_d   = own_lsb_q;
        io_d        = io_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        if_done_d   = if_done_q;
        lsb_done_d  = lsb_done_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        if (rdy) begin
            if_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_if || gnt_lsb) begin
                        last_lsb_d = gnt_lsb;
                        own_lsb_d  = gnt_lsb;
                        base_d     = gnt_lsb ? lsb_addr : if_addr;
                        n_d        = gnt_lsb ? lsb_n : 3'd4;
                        io_d       = gnt_lsb && lsb_io;
                        asm_d      = '0;
                        cnt_d      = '0;
                        mem_a_d    = base_d;
                        if (gnt_lsb && lsb_we) begin
                            wdata_d    = lsb_wdata;
                            mem_dout_d = lsb_wdata[7:0];
                            if (!(lsb_io && io_buffer_full)) begin
                                mem_wr_d = 1'b1;
                                cnt_d    = 3'd1;
                            end
                        end
                    end
                end
                READ: begin
                    if (!abort) begin
                        if (cnt_inc < n_q) mem_a_d = base_q + {29'd0, cnt_inc};
                        if (cnt_q != 3'd0) asm_d[{cnt_m1, 3'b000} +: 8] = mem_din;
                        if (cnt_q == n_q) begin
                            if (own_lsb_q) begin
                                lsb_rdata_d = asm_d;
                                lsb_done_d  = 1'b1;
                            end else begin
                                if_data_d = asm_d;
                                if_done_d = 1'b1;
                            end
                        end
                        cnt_d = cnt_inc;
                    end
                end
                WRITE: begin
                    if (cnt_q == n_q) begin
                        lsb_done_d = 1'b1;
                    end else if (!(io_q && io_buffer_full)) begin
                        mem_a_d    = base_q + {29'd0, cnt_q};
                        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                        cnt_d      = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign lsb_done  = lsb_done_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed scenarios
// with literal expectations; outputs compared on every falling edge.
module tb_mem_arbiter;
    logic        clk, rst, rdy, flush;
    logic        if_req, lsb_req, lsb_we, io_buffer_full;
    logic [31:0] if_addr, lsb_addr, lsb_wdata;
    logic [1:0]  lsb_size;
    logic [7:0]  mem_din;
    logic        if_done, lsb_done, mem_wr;
    logic [31:0] if_data, lsb_rdata, mem_a;
    logic [7:0]  mem_dout;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: preloaded bytes overlaid by bytes the DUT has written.
    logic [7:0] init_mem [0:262143];
    logic [7:0] wmem     [0:262143];
    bit         wr_valid [0:262143];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return wr_valid[a[17:0]] ? wmem[a[17:0]] : init_mem[a[17:0]];
    endfunction

    initial begin
        mem_din = 8'h00;
        forever begin
            @(posedge clk);
            mem_din <= rd_byte(mem_a);
            if (mem_wr) begin
                wmem[mem_a[17:0]]     <= mem_dout;
                wr_valid[mem_a[17:0]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, timed from its grant.
    localparam int PH_IDLE = 0, PH_READ = 1, PH_WRITE = 2, PH_DONE = 3;
    int          m_ph, m_t, m_n, m_beats;
    bit          m_last_lsb, m_lsb, m_io;
    logic [31:0] m_base, m_wd, m_word;
    logic [31:0] e_a, e_if_data, e_lsb_rdata;
    logic [7:0]  e_dout;
    logic        e_wr, e_if_done, e_lsb_done;

    task automatic m_reset();
        m_ph = PH_IDLE; m_last_lsb = 1'b1; m_lsb = 1'b0;
        e_a = '0; e_dout = '0; e_wr = 1'b0; e_if_done = 1'b0; e_lsb_done = 1'b0;
        e_if_data = '0; e_lsb_rdata = '0;
    endtask

    task automatic m_step();
        bit take_f, take_l;
        if (!rdy) begin
            e_wr = 1'b0;
            return;
        end
        e_wr = 1'b0; e_if_done = 1'b0; e_lsb_done = 1'b0;
        case (m_ph)
            PH_IDLE: begin
                take_f = if_req && !flush;
                take_l = lsb_req;
                if (take_f && take_l) begin
                    take_f = m_last_lsb;
                    take_l = !m_last_lsb;
                end
                if (take_f || take_l) begin
                    m_lsb = take_l; m_last_lsb = take_l; m_t = 0;
                    m_base = take_l ? lsb_addr : if_addr;
                    m_n = !take_l ? 4 : (lsb_size == 2'd0 ? 1 : (lsb_size == 2'd1 ? 2 : 4));
                    e_a = m_base;
                    if (take_l && lsb_we) begin
                        m_ph = PH_WRITE; m_wd = lsb_wdata; m_beats = 0;
                        m_io = (lsb_addr[17:16] == 2'b11);
                        e_dout = m_wd[7:0];
                        if (!(m_io && io_buffer_full)) begin
                            e_wr = 1'b1; m_beats = 1;
                        end
                    end else begin
                        m_ph = PH_READ; m_word = '0;
                        for (int k = 0; k < m_n; k++)
                            m_word = m_word | (32'(rd_byte(m_base + 32'(k))) << (8 * k));
                    end
                end
            end
            PH_READ: begin
                if (flush && !m_lsb) m_ph = PH_IDLE;
                else begin
                    m_t++;
                    if (m_t < m_n) e_a = m_base + 32'(m_t);
                    if (m_t == m_n + 1) begin
                        if (m_lsb) begin e_lsb_rdata = m_word; e_lsb_done = 1'b1; end
                        else       begin e_if_data = m_word;   e_if_done = 1'b1;  end
                        m_ph = PH_DONE;
                    end
                end
            end
            PH_WRITE: begin
                if (m_beats == m_n) begin
                    e_lsb_done = 1'b1; m_ph = PH_DONE;
                end else if (!(m_io && io_buffer_full)) begin
                    e_a = m_base + 32'(m_beats);
                    e_dout = 8'(m_wd >> (8 * m_beats));
                    e_wr = 1'b1;
                    m_beats++;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("mem_a", mem_a, e_a);
                chk("mem_dout", {24'd0, mem_dout}, {24'd0, e_dout});
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
                chk("if_done", {31'd0, if_done}, {31'd0, e_if_done});
                chk("lsb_done", {31'd0, lsb_done}, {31'd0, e_lsb_done});
                chk("if_data", if_data, e_if_data);
                chk("lsb_rdata", lsb_rdata, e_lsb_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit on_lsb, output int lat, output int wr_cnt);
        bit got = 1'b0;
        lat = 0; wr_cnt = 0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (mem_wr) wr_cnt++;
            got = on_lsb ? lsb_done : if_done;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_done timeout lsb=%0d", on_lsb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int lat, wc, n, ifd;
    int order [0:2];
    bit f_re, l_re;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; lsb_req = 1'b0; lsb_we = 1'b0;
        lsb_size = 2'd0; lsb_addr = '0; lsb_wdata = '0;
        for (int i = 0; i < 262144; i++) init_mem[i] = 8'h00;
        init_mem[18'h100] = 8'h13;
        init_mem[18'h205] = 8'hF0;
        init_mem[18'h500] = 8'h34; init_mem[18'h501] = 8'h12;
        init_mem[18'h600] = 8'h01; init_mem[18'h601] = 8'h02;
        init_mem[18'h602] = 8'h03; init_mem[18'h603] = 8'h04;
        init_mem[18'h3FFFE] = 8'h11; init_mem[18'h3FFFF] = 8'h22;
        init_mem[18'h00000] = 8'h33; init_mem[18'h00001] = 8'h44;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_if_done", {31'd0, if_done}, 32'h0);
        chk("rst_lsb_done", {31'd0, lsb_done}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsb_rdata", lsb_rdata, 32'h0);

        // fetch of 0x100
        if_addr = 32'h100; if_req = 1'b1;
        wait_done(1'b0, lat, wc);
        if_req = 1'b0;
        chk("fetch_latency", lat - 1, 5);
        chk("fetch_data", if_data, 32'h00000013);
        chk("model_fetch_data", e_if_data, 32'h00000013);
        step();

        // byte load
        lsb_addr = 32'h205; lsb_size = 2'd0; lsb_we = 1'b0; lsb_req = 1'b1;
        wait_done(1'b1, lat, wc);
        lsb_req = 1'b0;
        chk("bload_latency", lat - 1, 2);
        chk("bload_data", lsb_rdata, 32'h000000F0);
        chk("bload_no_write", wc, 0);
        step();

        // word store
        lsb_addr = 32'h400; lsb_size = 2'd2; lsb_we = 1'b1; lsb_wdata = 32'hDEADBEEF; lsb_req = 1'b1;
        wait_done(1'b1, lat, wc);
        lsb_req = 1'b0; lsb_we = 1'b0;
        chk("wstore_latency", lat - 1, 4);
        chk("wstore_wr_cycles", wc, 4);
        chk("wstore_ram", {rd_byte(32'h403), rd_byte(32'h402), rd_byte(32'h401), rd_byte(32'h400)},
            32'hDEADBEEF);
        step();

        // half load, then rdy low holds the done pulse
        lsb_addr = 32'h500; lsb_size = 2'd1; lsb_req = 1'b1;
        wait_done(1'b1, lat, wc);
        lsb_req = 1'b0;
        chk("hload_latency", lat - 1, 3);
        chk("hload_data", lsb_rdata, 32'h00001234);
        rdy = 1'b0;
        step(); step();
        chk("rdy_hold_done", {31'd0, lsb_done}, 32'h1);
        rdy = 1'b1;
        step();
        chk("rdy_release_done", {31'd0, lsb_done}, 32'h0);

        // fetch across the 2^32 wrap
        if_addr = 32'hFFFFFFFE; if_req = 1'b1;
        wait_done(1'b0, lat, wc);
        if_req = 1'b0;
        chk("wrap_data", if_data, 32'h44332211);
        step();

        // reset mid-fetch clears outputs immediately
        if_addr = 32'h100; if_req = 1'b1;
        step(); step();
        rst = 1'b1;
        #1 chk("async_rst_mem_a", mem_a, 32'h0);
        lsb_addr = 32'h600; lsb_size = 2'd2; lsb_we = 1'b0; lsb_req = 1'b1;
        step(); step();
        rst = 1'b0;

        // both requesting from reset: grants alternate fetch, LSB, fetch
        n = 0; f_re = 1'b0; l_re = 1'b0;
        for (int c = 0; c < 80 && n < 3; c++) begin
            step();
            if (f_re) begin if_req = 1'b1; f_re = 1'b0; end
            if (l_re) begin lsb_req = 1'b1; l_re = 1'b0; end
            if (if_done && n < 3)  begin order[n] = 0; n++; if_req = 1'b0; f_re = 1'b1; end
            if (lsb_done && n < 3) begin order[n] = 1; n++; lsb_req = 1'b0; l_re = 1'b1; end
        end
        if_req = 1'b0; lsb_req = 1'b0;
        chk("rr_count", n, 3);
        chk("rr_order", {29'd0, 1'(order[0]), 1'(order[1]), 1'(order[2])}, 32'b010);
        step(); step();

        // IO store stalled three cycles by a full buffer
        lsb_addr = 32'h30000; lsb_size = 2'd0; lsb_we = 1'b1; lsb_wdata = 32'h5A;
        io_buffer_full = 1'b1; lsb_req = 1'b1;
        wc = 0;
        repeat (3) begin
            step();
            if (mem_wr) wc++;
        end
        chk("io_stall_no_wr", wc, 0);
        io_buffer_full = 1'b0;
        wait_done(1'b1, lat, wc);
        lsb_req = 1'b0; lsb_we = 1'b0;
        chk("io_resume_latency", lat, 2);
        chk("io_single_beat", wc, 1);
        chk("io_ram", {24'd0, rd_byte(32'h30000)}, 32'h5A);
        step();

        // flush at second read beat of a fetch, store pending
        if_addr = 32'h100; if_req = 1'b1;
        lsb_addr = 32'h700; lsb_size = 2'd0; lsb_we = 1'b1; lsb_wdata = 32'h77; lsb_req = 1'b1;
        ifd = 0;
        step();
        chk("flush_fetch_granted", mem_a, 32'h100);
        step();
        chk("flush_second_beat", mem_a, 32'h101);
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0;
        if (if_done) ifd++;
        step();
        if (if_done) ifd++;
        chk("flush_lsb_grant_wr", {31'd0, mem_wr}, 32'h1);
        chk("flush_lsb_grant_a", mem_a, 32'h700);
        wait_done(1'b1, lat, wc);
        lsb_req = 1'b0; lsb_we = 1'b0;
        chk("flush_lsb_latency", lat, 1);
        repeat (4) begin
            step();
            if (if_done) ifd++;
        end
        chk("flush_no_if_done", ifd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide RAM/IO port. Shares that port between instruction fetch (always 4-byte reads) and the load/store buffer (LSB; reads and writes of 1, 2 or 4 bytes).
- Serialises each request into byte beats and reassembles read data little-endian.
- Arbitrates round-robin between the two requesters, stalls IO writes while the IO buffer is full, and aborts in-flight fetches on pipeline flush.

Parameters:
- IO_ADDR_HI, 2'b11: value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  misprediction rollback; aborts an active fetch.
- if_req  in  1  fetch request, held until if_done or flush.
- if_addr  in  32  fetch base address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word.
- lsb_req  in  1  LSB request, held until lsb_done.
- lsb_we  in  1  1 = store, 0 = load.
- lsb_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- lsb_addr  in  32  access base address.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_done  out  1  one-cycle pulse; load data valid / store finished.
- lsb_rdata  out  32  load data, zero-extended; the LSB sign-extends.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write beat.
- io_buffer_full  in  1  IO output buffer cannot accept a byte.

Behaviour:
- Reset:
  - state = IDLE, last_grant = LSB.
  - All outputs 0: mem_a, mem_dout, mem_wr, if_done, lsb_done, if_data, lsb_rdata.
  - Byte counter = 0, assembly register = 0.
  - Reset mid-transaction discards it; nothing is replayed.
- rdy low:
  - State, counter and outputs hold, except mem_wr, which is forced 0.
  - A done pulse already high stays high until the next enabled edge.
- All outputs are registered. N = 1, 2 or 4 bytes (fetch N = 4).
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant, then update last_grant.
  - Latch base address, N, write data and owner.
  - Drive mem_a = base and, for a write, mem_dout = byte0 and mem_wr = 1.
  - Next state is READ or WRITE.
- READ:
  - The beat presented on mem_a in cycle k returns on mem_din in cycle k+1.
  - Present bytes 0..N-1 on consecutive cycles; each returned byte k lands in assembly bits [8k+7:8k].
  - The edge that captures byte N-1 loads if_data or lsb_rdata (upper bytes 0), raises the owner's done and moves to DONE.
  - Latency from grant edge to done high is N+1 cycles.
  - mem_wr stays 0.
- WRITE:
  - Beat k drives mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - After beat N-1, raise lsb_done and move to DONE. Latency from grant edge is N cycles.
  - IO stall: if base[17:16] == IO_ADDR_HI and io_buffer_full is high, the pending beat is not issued. mem_wr = 0, counter frozen; the beat resumes the cycle after io_buffer_full falls.
  - A grant into an IO write while the buffer is full starts in the stalled condition.
- DONE:
  - Done is high for this one cycle; requests are ignored; mem_wr = 0.
  - Next state is IDLE. The earliest next grant is the edge after DONE, so a held request is never double-accepted.
- Address wrap: base+k wraps modulo 2^32.
- flush:
  - Sampled every enabled cycle.
  - If owner = fetch in READ or DONE: go to IDLE next edge, drop if_done (forced 0), clear mem_wr.
  - In IDLE, flush blocks a fetch grant that cycle; the LSB may still be granted.
  - LSB transactions are never aborted by flush (stores are committed).
- Outputs not owned by the active transaction hold their last value.

Test Plan:
- Fetch only, if_addr = 0x100, RAM[0x100..0x103] = 13,00,00,00 → mem_a 0x100..0x103 on consecutive cycles; if_done high 5 cycles after grant edge, if_data = 0x00000013.
- LSB byte load: lsb_size = 0, addr 0x205, RAM = 0xF0 → lsb_done after 2 cycles, lsb_rdata = 0x000000F0; mem_wr never high.
- LSB word store: addr 0x400, wdata 0xDEADBEEF → mem_wr high 4 cycles, mem_dout EF,BE,AD,DE at 0x400..0x403; lsb_done next cycle.
- if_req and lsb_req both high from reset, each re-requesting after done → grants alternate fetch, LSB, fetch; no grant during any DONE cycle.
- IO store: addr 0x30000, size 0, io_buffer_full high 3 cycles → mem_wr stays 0 for those 3 cycles, then a single beat, then lsb_done.
- flush at second READ beat of a fetch, with lsb_req pending → no if_done; the LSB is granted on the IDLE edge after the abort.
